rib_nxm: RTL and testbench

Parametrised N-master/M-slave RISC-V internal bus (RIB) interconnect for the SoC top, replacing the fixed core-to-rom/ram wiring and carrying the JTAG debug master. It arbitrates master requests in fixed-priority or round-robin order, decodes the winning address onto one slave, and returns an acknowledge with read data. It also drives a pipeline hold flag to the core while a transfer is in flight.

---
 rtl/rib_pkg.sv | 17 +
 rtl/rib_rr_arbiter.sv | 31 +++
 rtl/rib_nxm.sv | 143 ++++++++++++++
 tb/tb_rib_nxm.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rib_pkg.sv
// Shared definitions for the RIB N-master/M-slave interconnect:
// FSM encoding, slave-select field width and arbitration mode constants.
package rib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } rib_state_e;

  // The slave index occupies the top SEL_W address bits.
  localparam int SEL_W = 4;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/rib_rr_arbiter.sv
// NM-wide priority picker: the first set request found searching upward
// from base_i (wrapping NM-1 -> 0) wins. Tie base_i to 0 for fixed priority.
module rib_rr_arbiter #(
  parameter int NM = 4,
  parameter int IW = 2
) (
  input  logic [NM-1:0] req_i,
  input  logic [IW-1:0] base_i,
  output logic          gnt_vld_o,
  output logic [IW-1:0] gnt_idx_o
);

  int cand;

  // Walk offsets from highest to lowest so the smallest offset is the last
  // (and therefore winning) assignment, avoiding an early loop exit.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    cand      = 0;
    for (int i = NM - 1; i >= 0; i--) begin
      cand = int'(base_i) + i;
      if (cand >= NM) cand = cand - NM;
      if (req_i[IW'(cand)]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/rib_nxm.sv
// RIB interconnect top: arbitrates NM masters, decodes the winner onto one of
// NS slaves, returns ack/read data/error and drives the core hold flag.
module rib_nxm
  import rib_pkg::*;
#(
  parameter int NM       = 4,
  parameter int NS       = 3,
  parameter int ARB_MODE = 1,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM-1:0]    m_req_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*AW-1:0] m_addr_i,
  input  logic [NM*DW-1:0] m_data_i,
  output logic [DW-1:0]    m_data_o,
  output logic [NM-1:0]    m_ack_o,
  output logic             m_err_o,
  output logic             hold_flag_o,
  output logic [NS*AW-1:0] s_addr_o,
  output logic [NS*DW-1:0] s_data_o,
  output logic [NS-1:0]    s_we_o,
  input  logic [NS*DW-1:0] s_data_i
);

  localparam int IW = $clog2(NM);

  rib_state_e      state_q, state_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;
  logic             sel_we;
  logic [SEL_W-1:0] sidx;
  logic             mapped;

  logic [NM-1:0] arb_req;
  logic [IW-1:0] arb_base;
  logic          arb_vld;
  logic [IW-1:0] arb_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_we   = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (IW'(k) == gidx_q) begin
        sel_addr = m_addr_i[k*AW +: AW];
        sel_data = m_data_i[k*DW +: DW];
        sel_we   = m_we_i[k];
      end
    end
  end

  assign sidx   = sel_addr[AW-1 -: SEL_W];
  assign mapped = (int'(sidx) < NS);

  // In RESP the master just served is excluded: its still-high request
  // belongs to the transfer that is completing this cycle.
  always_comb begin
    arb_req = m_req_i;
    if (state_q == ST_RESP) arb_req[gidx_q] = 1'b0;
  end

  assign arb_base = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;

  rib_rr_arbiter #(
    .NM (NM),
    .IW (IW)
  ) u_arb (
    .req_i     (arb_req),
    .base_i    (arb_base),
    .gnt_vld_o (arb_vld),
    .gnt_idx_o (arb_idx)
  );

  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (arb_vld) begin
          state_d  = ST_ADDR;
          gidx_d   = arb_idx;
          rr_ptr_d = (arb_idx == IW'(NM - 1)) ? '0 : IW'(arb_idx + 1'b1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Address and write data fan out to every slave unqualified; only the
  // write strobe is decoded.
  always_comb begin
    s_we_o   = '0;
    s_addr_o = '0;
    s_data_o = '0;
    m_ack_o  = '0;
    m_err_o  = 1'b0;
    m_data_o = '0;
    for (int s = 0; s < NS; s++) begin
      s_addr_o[s*AW +: AW] = sel_addr;
      s_data_o[s*DW +: DW] = sel_data;
    end
    if (state_q == ST_ADDR && mapped && sel_we) begin
      for (int s = 0; s < NS; s++) begin
        if (int'(sidx) == s) s_we_o[s] = 1'b1;
      end
    end
    if (state_q == ST_RESP) begin
      m_ack_o[gidx_q] = 1'b1;
      if (mapped) begin
        for (int s = 0; s < NS; s++) begin
          if (int'(sidx) == s) m_data_o = s_data_i[s*DW +: DW];
        end
      end else begin
        m_err_o = 1'b1;
      end
    end
  end

  assign hold_flag_o = (state_q != ST_IDLE) | (|m_req_i);

endmodule

// File: tb/tb_rib_nxm.sv
// Scoreboard bench for rib_nxm: randomized master transactions against a
// transaction-level model of arbitration order, slave memories and timing.
module tb_rib_nxm;

  localparam int NM = 4;
  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NM-1:0]    m_req_i;
  logic [NM-1:0]    m_we_i;
  logic [NM*AW-1:0] m_addr_i;
  logic [NM*DW-1:0] m_data_i;
  logic [DW-1:0]    m_data_o;
  logic [NM-1:0]    m_ack_o;
  logic             m_err_o;
  logic             hold_flag_o;
  logic [NS*AW-1:0] s_addr_o;
  logic [NS*DW-1:0] s_data_o;
  logic [NS-1:0]    s_we_o;
  logic [NS*DW-1:0] s_data_i;

  logic [DW-1:0]    f_data_o;
  logic [NM-1:0]    f_ack_o;
  logic             f_err_o;
  logic             f_hold;
  logic [NS*AW-1:0] f_s_addr;
  logic [NS*DW-1:0] f_s_data;
  logic [NS-1:0]    f_s_we;
  logic [NS*DW-1:0] f_s_data_i;
  assign f_s_data_i = '0;

  rib_nxm #(.NM(NM), .NS(NS), .ARB_MODE(1), .AW(AW), .DW(DW)) u_dut (
    .clk(clk), .rst(rst), .m_req_i(m_req_i), .m_we_i(m_we_i),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_data_o(m_data_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .hold_flag_o(hold_flag_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o),
    .s_data_i(s_data_i)
  );

  rib_nxm #(.NM(NM), .NS(NS), .ARB_MODE(0), .AW(AW), .DW(DW)) u_fix (
    .clk(clk), .rst(rst), .m_req_i(m_req_i), .m_we_i(m_we_i),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_data_o(f_data_o),
    .m_ack_o(f_ack_o), .m_err_o(f_err_o), .hold_flag_o(f_hold),
    .s_addr_o(f_s_addr), .s_data_o(f_s_data), .s_we_o(f_s_we),
    .s_data_i(f_s_data_i)
  );

  typedef struct {
    int          m;
    logic [31:0] data;
    logic        err;
    logic        we;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_cnt = 0;
  int ack_seen = 0;
  int last_ws;
  logic [31:0] last_wa, last_wd;
  logic [31:0] slv_mem [NS][16];
  logic [31:0] ref_mem [NS][16];
  logic [NM-1:0] fix_log[$];
  bit fix_en = 0;

  logic [31:0] b_addr [NM];
  logic [31:0] b_data [NM];
  logic        b_we   [NM];
  int ptr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Slave environment: synchronous write, read data registered one cycle
  // after the address.
  always @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      if (s_we_o[s]) begin
        slv_mem[s][s_addr_o[s*AW+2 +: 4]] <= s_data_o[s*DW +: DW];
        last_ws <= s;
        last_wa <= s_addr_o[s*AW +: AW];
        last_wd <= s_data_o[s*DW +: DW];
      end
      s_data_i[s*DW +: DW] <= slv_mem[s][s_addr_o[s*AW+2 +: 4]];
    end
    we_cnt <= we_cnt + $countones(s_we_o);
  end

  // Monitor: compares every ack against the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) chk("hold_busy", hold_flag_o, 1);
    if (m_ack_o != '0) begin
      ack_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got %b expected none", m_ack_o);
      end else begin
        e = sb.pop_front();
        chk("ack_vec", m_ack_o, 64'(1) << e.m);
        chk("ack_cycle", cyc, e.cyc);
        chk("err_flag", m_err_o, e.err);
        if (!e.we) chk("rdata", m_data_o, e.data);
      end
    end
    if (fix_en && f_ack_o != '0) fix_log.push_back(f_ack_o);
  end

  // Issue one group of simultaneous requests. n_cont = 0: each master in
  // 'set' performs one transfer and drops on its ack. n_cont > 0: all masters
  // hold requests for n_cont acks.
  task automatic run(input logic [NM-1:0] set, input int n_cont);
    int order[$];
    int c, w0, wexp, k, si, w, n_ack, total, budget;
    exp_t e;
    if (n_cont == 0) begin
      for (int i = 0; i < NM; i++) begin
        k = (ptr + i) % NM;
        if (set[k]) order.push_back(k);
      end
    end else begin
      for (int j = 0; j < n_cont; j++) order.push_back((ptr + j) % NM);
    end
    @(posedge clk); #1;
    c = cyc;
    w0 = we_cnt;
    wexp = 0;
    foreach (order[j]) begin
      k  = order[j];
      si = int'(b_addr[k][31:28]);
      w  = int'(b_addr[k][5:2]);
      e.m = k;
      e.we = b_we[k];
      e.err = (si >= NS);
      e.cyc = c + 2 + 2 * j;
      e.data = 32'h0;
      if (si < NS) begin
        e.data = ref_mem[si][w];
        if (b_we[k]) begin
          ref_mem[si][w] = b_data[k];
          wexp++;
        end
      end
      sb.push_back(e);
    end
    total = order.size();
    if (total > 0) ptr = (order[total-1] + 1) % NM;
    for (int i = 0; i < NM; i++) begin
      m_addr_i[i*AW +: AW] = b_addr[i];
      m_data_i[i*DW +: DW] = b_data[i];
      m_we_i[i] = b_we[i];
    end
    m_req_i = set;
    n_ack = 0;
    budget = 2 * total + 10;
    while (n_ack < total && budget > 0) begin
      @(negedge clk);
      budget--;
      if (m_ack_o != '0) begin
        n_ack++;
        if (n_cont == 0) m_req_i = m_req_i & ~m_ack_o;
        else if (n_ack == total) m_req_i = '0;
      end
    end
    if (n_ack < total) begin
      checks++;
      errors++;
      $display("FAIL batch_timeout: got %0d acks expected %0d", n_ack, total);
      m_req_i = '0;
    end
    @(posedge clk); #1;
    sb.delete();
    chk("we_count", 64'(we_cnt - w0), 64'(wexp));
    @(posedge clk); #1;
    chk("hold_idle", hold_flag_o, 0);
  endtask

  initial begin
    int sel, nib, a0;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, nib, a0;
    rst = 1'b0;
    m_req_i = '0;
    m_we_i = '0;
    m_addr_i = '0;
    m_data_i = '0;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < 16; w++) begin
        slv_mem[s][w] = $urandom;
        ref_mem[s][w] = slv_mem[s][w];
      end
    for (int k = 0; k < NM; k++) begin
      b_addr[k] = 32'h0;
      b_data[k] = 32'h0;
      b_we[k] = 1'b0;
    end
    slv_mem[1][1] = 32'hDEADBEEF;
    ref_mem[1][1] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", m_ack_o, 0);
    chk("rst_we", s_we_o, 0);
    chk("rst_err", m_err_o, 0);
    chk("rst_data", m_data_o, 0);
    chk("rst_hold", hold_flag_o, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ack", m_ack_o, 0);

    // Single read: master 1, slave 1 word 1.
    b_addr[1] = 32'h1000_0004; b_we[1] = 1'b0;
    run(4'b0010, 0);
    // Single write: master 0 to slave 0.
    b_addr[0] = 32'h0000_0010; b_we[0] = 1'b1; b_data[0] = 32'h1234_5678;
    run(4'b0001, 0);
    chk("wr_slave", 64'(last_ws), 0);
    chk("wr_addr", last_wa, 32'h0000_0010);
    chk("wr_data", last_wd, 32'h1234_5678);
    // Unmapped read.
    b_addr[2] = 32'hF000_0000; b_we[2] = 1'b0;
    run(4'b0100, 0);
    // Pointer wrap: grant 3, then 0 and 3 contend.
    b_addr[3] = 32'h2000_0008; b_we[3] = 1'b0;
    run(4'b1000, 0);
    b_addr[0] = 32'h1000_0000; b_we[0] = 1'b0;
    run(4'b1001, 0);

    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < NM; k++) begin
        sel = $urandom_range(0, 4);
        nib = (sel == 4) ? 15 : sel;
        b_addr[k] = ($urandom & 32'h0FFF_FFFC & 32'h0000_003C) | (32'(nib) << 28);
        b_we[k] = 1'($urandom_range(0, 1));
        b_data[k] = $urandom;
      end
      run(4'($urandom_range(1, 15)), 0);
    end

    // Asynchronous reset in the ADDR cycle of a write.
    b_addr[2] = 32'h0000_000C; b_we[2] = 1'b1; b_data[2] = 32'hCAFE_F00D;
    m_addr_i[2*AW +: AW] = b_addr[2];
    m_data_i[2*DW +: DW] = b_data[2];
    m_we_i = 4'b0100;
    @(posedge clk); #1;
    m_req_i = 4'b0100;
    @(posedge clk); #1;
    chk("addr_we", s_we_o, 3'b001);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_we", s_we_o, 0);
    chk("arst_ack", m_ack_o, 0);
    chk("arst_err", m_err_o, 0);
    chk("arst_data", m_data_o, 0);
    m_req_i = '0;
    m_we_i = '0;
    ptr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    a0 = ack_seen;
    repeat (6) @(posedge clk);
    #1;
    chk("no_ack_after_rst", 64'(ack_seen - a0), 0);
    chk("write_not_captured", slv_mem[0][3], ref_mem[0][3]);

    // Continuous contention from all masters.
    for (int k = 0; k < NM; k++) begin
      b_addr[k] = (32'(k % NS) << 28) | (32'(k) << 2);
      b_we[k] = 1'b0;
    end
    fix_en = 1;
    run(4'b1111, 8);
    fix_en = 0;
    if (fix_log.size() < 6) begin
      checks++;
      errors++;
      $display("FAIL fixed_grants: got %0d acks expected 6", fix_log.size());
    end else begin
      for (int j = 0; j < 6; j++)
        chk("fixed_order", fix_log[j], (j % 2 == 0) ? 4'b0001 : 4'b0010);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
